// File: rtl/i2s_capture.sv
// Purpose: Philips-I2S ADC receiver; recovers stereo {left,right} frames into a show-ahead FIFO.
// Latency: a frame is pushed at the end of the cycle after the last right-bit BCLK rise; valid follows one cycle later.
// Backpressure: valid/ready pop; when the FIFO is full and not popping, the new frame is dropped and overflow_o sticks.
module i2s_capture #(
    parameter int SAMPLE_W   = 16,   // at least 2
    parameter int FIFO_DEPTH = 4     // power of two, at least 2
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          enable_i,
    input  logic                          bclk_i,
    input  logic                          lrc_i,
    input  logic                          sda_i,
    output logic                          sample_valid_o,
    input  logic                          sample_ready_i,
    output logic [SAMPLE_W-1:0]           sample_left_o,
    output logic [SAMPLE_W-1:0]           sample_right_o,
    output logic [$clog2(FIFO_DEPTH):0]   level_o,
    output logic                          overflow_o,
    output logic                          framing_err_o,
    input  logic                          err_clr_i
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = (SAMPLE_W > 1) ? $clog2(SAMPLE_W) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SAMPLE_W - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SYNC  = 2'd1,
        S_SHIFT = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    // Bit-clock edge detection and sampled serial inputs
    logic bclk_q;
    logic rise;
    logic rise_q;
    logic lrc_s;
    logic sda_s;
    logic lrc_prev;
    logic lrc_chg;

    // Deserialiser state
    state_t                state_q;
    state_t                state_d;
    logic [SAMPLE_W-2:0]   shreg;
    logic [SAMPLE_W-1:0]   word_in;
    logic [CW-1:0]         cnt;
    logic                  ch;          // 0 = left, 1 = right
    logic [SAMPLE_W-1:0]   left_hold;
    logic                  left_ok;

    // FSM strobes
    logic start_slot;
    logic shift_en;
    logic word_done;
    logic short_slot;
    logic push_req;

    // FIFO
    logic [SAMPLE_W-1:0] mem_l [FIFO_DEPTH];
    logic [SAMPLE_W-1:0] mem_r [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic                full;
    logic                pop;
    logic                push_ok;
    logic                drop;

    assign rise = bclk_i & ~bclk_q;

    // Delay bclk by one cycle for rising-edge detection
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bclk_q <= 1'b0;
        end else begin
            bclk_q <= bclk_i;
        end
    end

    // Capture lrc/sda at each BCLK rise; the FSM acts on them one cycle later
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rise_q <= 1'b0;
            lrc_s  <= 1'b0;
            sda_s  <= 1'b0;
        end else begin
            rise_q <= rise;
            if (rise) begin
                lrc_s <= lrc_i;
                sda_s <= sda_i;
            end
        end
    end

    // Remember the word-select level seen at the previous rise
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lrc_prev <= 1'b0;
        end else if (rise_q) begin
            lrc_prev <= lrc_s;
        end
    end

    // A rise with a changed LRC is the I2S delay bit of a new slot
    assign lrc_chg = rise_q & (lrc_s != lrc_prev);
    assign word_in = {shreg, sda_s};

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-rise strobes
    always_comb begin
        state_d    = state_q;
        start_slot = 1'b0;
        shift_en   = 1'b0;
        word_done  = 1'b0;
        short_slot = 1'b0;
        case (state_q)
            S_IDLE: begin
                state_d = S_SYNC;
            end
            S_SYNC: begin
                // Only lock on a left slot so a partial right-first frame is never built
                if (lrc_chg && !lrc_s) begin
                    state_d    = S_SHIFT;
                    start_slot = 1'b1;
                end
            end
            S_SHIFT: begin
                if (lrc_chg) begin
                    // Slot ended before the word filled: drop it and resync on the new slot
                    short_slot = 1'b1;
                    start_slot = 1'b1;
                end else if (rise_q) begin
                    shift_en = 1'b1;
                    if (cnt == CNT_LAST) begin
                        word_done = 1'b1;
                        state_d   = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (lrc_chg) begin
                    state_d    = S_SHIFT;
                    start_slot = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (!enable_i) begin
            state_d    = S_IDLE;
            start_slot = 1'b0;
            shift_en   = 1'b0;
            word_done  = 1'b0;
            short_slot = 1'b0;
        end
    end

    // A frame is complete when the right word finishes after a good left word
    assign push_req = word_done & ch & left_ok;

    // Shift register, bit counter, channel and left-word holding register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shreg     <= '0;
            cnt       <= '0;
            ch        <= 1'b0;
            left_hold <= '0;
            left_ok   <= 1'b0;
        end else begin
            if (start_slot) begin
                ch  <= lrc_s;
                cnt <= '0;
            end
            if (shift_en) begin
                shreg <= word_in[SAMPLE_W-2:0];
                cnt   <= cnt + 1'b1;
            end
            if (word_done) begin
                if (!ch) begin
                    left_hold <= word_in;
                    left_ok   <= 1'b1;
                end else begin
                    left_ok   <= 1'b0;
                end
            end
            if (short_slot || !enable_i) begin
                left_ok <= 1'b0;
            end
        end
    end

    // Framing error is sticky; a new error beats a simultaneous clear
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            framing_err_o <= 1'b0;
        end else if (short_slot) begin
            framing_err_o <= 1'b1;
        end else if (err_clr_i) begin
            framing_err_o <= 1'b0;
        end
    end

    assign sample_valid_o = (level_o != '0);
    assign full           = (level_o == LW'(FIFO_DEPTH));
    assign pop            = sample_valid_o & sample_ready_i;
    // When full, a same-cycle pop frees the slot the push writes into
    assign push_ok        = push_req & (~full | pop);
    assign drop           = push_req & full & ~pop;

    // FIFO storage writes (no reset needed; outputs are masked while empty)
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_l[wr_ptr] <= left_hold;
            mem_r[wr_ptr] <= word_in;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_o <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   level_o <= level_o + 1'b1;
                2'b01:   level_o <= level_o - 1'b1;
                default: level_o <= level_o;
            endcase
        end
    end

    // Overflow is sticky; a drop beats a simultaneous clear
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            overflow_o <= 1'b0;
        end else if (drop) begin
            overflow_o <= 1'b1;
        end else if (err_clr_i) begin
            overflow_o <= 1'b0;
        end
    end

    assign sample_left_o  = sample_valid_o ? mem_l[rd_ptr] : '0;
    assign sample_right_o = sample_valid_o ? mem_r[rd_ptr] : '0;

endmodule

// File: tb/tb_i2s_capture.sv
module tb_i2s_capture;

    localparam int SW    = 16;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        bclk;
    logic        lrc;
    logic        sda;
    logic        ready;
    logic        err_clr;
    logic        valid;
    logic [15:0] left;
    logic [15:0] right;
    logic [2:0]  level;
    logic        ovf;
    logic        ferr;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int last_r = -1;

    logic [31:0] popq [$];
    int          riseq [$];
    logic        vprev = 1'b0;

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        int          slot;
        logic [31:0] exp_pair;
        int          exp_lat;
    } vec_t;

    vec_t vecs [4];

    i2s_capture #(.SAMPLE_W(SW), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .enable_i       (enable),
        .bclk_i         (bclk),
        .lrc_i          (lrc),
        .sda_i          (sda),
        .sample_valid_o (valid),
        .sample_ready_i (ready),
        .sample_left_o  (left),
        .sample_right_o (right),
        .level_o        (level),
        .overflow_o     (ovf),
        .framing_err_o  (ferr),
        .err_clr_i      (err_clr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every accepted pop and every rising edge of valid
    always @(negedge clk) begin
        if (valid && ready) popq.push_back({left, right});
        if (valid && !vprev) riseq.push_back(cyc);
        vprev = valid;
    end

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One BCLK period: 4 clk low, 4 clk high. hook 1 pulses err_clr, hook 2 pulses
    // ready, in the cycle right after the rise cycle (the push cycle).
    task automatic send_bit(input logic l, input logic d, input int hook, input bit mark);
        bclk = 1'b0;
        lrc  = l;
        sda  = d;
        repeat (4) tick();
        bclk = 1'b1;
        if (mark) last_r = cyc;
        tick();
        if (hook == 1) err_clr = 1'b1;
        if (hook == 2) ready = 1'b1;
        tick();
        if (hook == 1) err_clr = 1'b0;
        if (hook == 2) ready = 1'b0;
        tick();
        tick();
    endtask

    // nslot BCLKs with LRC=l: delay bit, then ndata MSB-first bits of w, padding of ones
    task automatic send_slot(input logic l, input logic [15:0] w, input int ndata,
                             input int nslot, input int hook, input int en_at);
        for (int j = 0; j < nslot; j++) begin
            logic d;
            bit   last;
            if (j == en_at) enable = 1'b1;
            last = (j == ndata) && (ndata == SW) && (l == 1'b1);
            if (j == 0 || j > ndata) d = 1'b1;
            else                     d = w[SW-j];
            send_bit(l, d, last ? hook : 0, last);
        end
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input int slot, input int hook);
        send_slot(1'b0, l, SW, slot, 0, -1);
        send_slot(1'b1, r, SW, slot, hook, -1);
    endtask

    initial begin
        int pb;
        int rb;

        vecs[0] = '{16'hA55A, 16'h1234, 32, 32'hA55A_1234, 2};
        vecs[1] = '{16'hFFFF, 16'h0000, 17, 32'hFFFF_0000, 2};
        vecs[2] = '{16'h0001, 16'h8000, 24, 32'h0001_8000, 2};
        vecs[3] = '{16'hC3C3, 16'h5AA5, 20, 32'hC3C3_5AA5, 2};

        rst     = 1'b1;
        enable  = 1'b0;
        bclk    = 1'b0;
        lrc     = 1'b1;
        sda     = 1'b0;
        ready   = 1'b1;
        err_clr = 1'b0;
        repeat (3) tick();
        check("reset_valid", valid, 0);
        check("reset_level", level, 0);
        check("reset_left",  left,  0);
        check("reset_right", right, 0);
        check("reset_ovf",   ovf,   0);
        check("reset_ferr",  ferr,  0);

        rst    = 1'b0;
        enable = 1'b1;
        tick();
        send_slot(1'b1, 16'h0000, 0, 4, 0, -1);

        // Basic capture over several patterns and slot widths
        for (int i = 0; i < 4; i++) begin
            pb = popq.size();
            rb = riseq.size();
            send_frame(vecs[i].l, vecs[i].r, vecs[i].slot, 0);
            repeat (4) tick();
            check($sformatf("vec%0d_npop", i), popq.size() - pb, 1);
            if (popq.size() > pb) check($sformatf("vec%0d_pair", i), popq[pb], vecs[i].exp_pair);
            if (riseq.size() > rb) check($sformatf("vec%0d_latency", i), riseq[rb] - last_r, vecs[i].exp_lat);
            else check($sformatf("vec%0d_latency_none", i), 0, 1);
            check($sformatf("vec%0d_level", i), level, 0);
        end

        // Overflow: five frames into a four-deep FIFO
        ready = 1'b0;
        pb = popq.size();
        for (int n = 1; n <= 5; n++) send_frame(16'(n), 16'(16'h0100 + n), 32, 0);
        check("ovf_level", level, 4);
        check("ovf_flag",  ovf,   1);
        check("ovf_head",  {left, right}, 32'h0001_0101);
        check("ovf_ferr",  ferr,  0);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        check("ovf_clear", ovf, 0);

        // Clear coincident with a drop: set wins
        send_frame(16'h0006, 16'h0106, 32, 1);
        check("race_ovf",   ovf,   1);
        check("race_level", level, 4);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        check("race_clear", ovf, 0);

        // Push and pop in the same cycle while full
        send_frame(16'h0007, 16'h0107, 32, 2);
        check("pp_level", level, 4);
        check("pp_ovf",   ovf,   0);
        ready = 1'b1;
        repeat (10) tick();
        check("drain_npop", popq.size() - pb, 5);
        if (popq.size() - pb == 5) begin
            check("drain_0", popq[pb],   32'h0001_0101);
            check("drain_1", popq[pb+1], 32'h0002_0102);
            check("drain_2", popq[pb+2], 32'h0003_0103);
            check("drain_3", popq[pb+3], 32'h0004_0104);
            check("drain_4", popq[pb+4], 32'h0007_0107);
        end
        check("drain_level", level, 0);

        // Enable asserted inside a right slot
        enable = 1'b0;
        tick();
        pb = popq.size();
        send_slot(1'b0, 16'h1111, SW, 32, 0, -1);
        send_slot(1'b1, 16'h2222, SW, 32, 0, 3);
        send_frame(16'h3333, 16'h4444, 32, 0);
        repeat (4) tick();
        check("midena_npop", popq.size() - pb, 1);
        if (popq.size() > pb) check("midena_pair", popq[pb], 32'h3333_4444);

        // Short left slot
        pb = popq.size();
        check("short_ferr_before", ferr, 0);
        send_slot(1'b0, 16'h5555, 10, 11, 0, -1);
        send_slot(1'b1, 16'h6666, SW, 32, 0, -1);
        send_frame(16'h789A, 16'hBCDE, 32, 0);
        repeat (4) tick();
        check("short_ferr", ferr, 1);
        check("short_npop", popq.size() - pb, 1);
        if (popq.size() > pb) check("short_pair", popq[pb], 32'h789A_BCDE);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        check("short_clear", ferr, 0);

        // Reset with two frames queued, an error flagged and a partial left word
        ready = 1'b0;
        pb = popq.size();
        send_slot(1'b0, 16'h5555, 10, 11, 0, -1);
        send_slot(1'b1, 16'h6666, SW, 32, 0, -1);
        send_frame(16'h0A0A, 16'h0B0B, 32, 0);
        send_frame(16'h0C0C, 16'h0D0D, 32, 0);
        check("rst_pre_level", level, 2);
        check("rst_pre_ferr",  ferr,  1);
        send_slot(1'b0, 16'hFFFF, SW, 6, 0, -1);
        rst = 1'b1; tick(); rst = 1'b0;
        check("rst_level", level, 0);
        check("rst_valid", valid, 0);
        check("rst_left",  left,  0);
        check("rst_ferr",  ferr,  0);
        check("rst_ovf",   ovf,   0);
        ready = 1'b1;
        send_slot(1'b0, 16'hFFFF, SW, 26, 0, -1);
        send_slot(1'b1, 16'hEEEE, SW, 32, 0, -1);
        send_frame(16'h1357, 16'h2468, 32, 0);
        repeat (4) tick();
        check("rst_npop", popq.size() - pb, 1);
        if (popq.size() > pb) check("rst_pair", popq[pb], 32'h1357_2468);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/i2s_capture.md
# i2s_capture

Serial-to-parallel receiver for the Wolfson codec ADC path (`codec_adcdat`). It is the counterpart of the `i2s_stream` DAC transmitter and shares its `bclk`/`lrc` pair in the `codec_clk` domain. It recovers Philips-I2S stereo frames (MSB first, one BCLK delay after each LRC edge, LRC low = left) into a small show-ahead FIFO. A valid/ready interface delivers `{left,right}` sample pairs to the SoC side.

## Interface
- `SAMPLE_W`, 16: bits captured per channel; bits beyond this in a slot are ignored.
- `FIFO_DEPTH`, 4: stereo frames buffered; power of two, ≥2.

Ports:
- `clk_i` in 1: `codec_clk`; single clock for all logic.
- `rst_i` in 1: synchronous, active-high reset.
- `enable_i` in 1: capture enable.
- `bclk_i` in 1: bit clock, already synchronous to `clk_i`.
- `lrc_i` in 1: word select, synchronous to `clk_i`.
- `sda_i` in 1: ADC serial data, synchronous to `clk_i`.
- `sample_valid_o` out 1: FIFO head valid.
- `sample_ready_i` in 1: consumer accepts the head.
- `sample_left_o` out SAMPLE_W: head left sample.
- `sample_right_o` out SAMPLE_W: head right sample.
- `level_o` out clog2(FIFO_DEPTH)+1: FIFO occupancy.
- `overflow_o` out 1: sticky; a frame was dropped because the FIFO was full.
- `framing_err_o` out 1: sticky; a slot ended before SAMPLE_W bits.
- `err_clr_i` in 1: clears both sticky flags.

## Operation
- Bit-clock edge detect: `bclk_q` is `bclk_i` delayed one cycle. `rise = bclk_i & ~bclk_q`. `lrc_i` and `sda_i` are sampled only in `rise` cycles. `lrc_prev` holds the `lrc_i` value at the previous `rise`.
- At a `rise`, `lrc_chg = (lrc_i != lrc_prev)`. The bit sampled in that cycle is the I2S delay bit and is discarded. The MSB arrives on the next `rise`.
- States:
  - IDLE: no capture. Enters SYNC when `enable_i` is 1.
  - SYNC: waits for a `rise` with `lrc_chg` and `lrc_i=0`, then goes to SHIFT with `ch=L`, `cnt=0`. Right-first partial frames are never captured.
  - SHIFT: each `rise` without `lrc_chg` shifts `sda_i` into `shreg` (MSB first) and increments `cnt`.
    - On the `rise` where `cnt==SAMPLE_W-1`, the word completes. For `ch=L`: `left_hold<=word`, `left_ok<=1`. For `ch=R`: if `left_ok`, push `{left_hold,word}` and clear `left_ok`.
    - After completion, go to HOLD.
    - A `rise` with `lrc_chg` while still in SHIFT is a short slot: discard the word, set `framing_err_o`, clear `left_ok`, restart SHIFT with `ch=lrc_i`, `cnt=0`.
  - HOLD: ignores bits. A `rise` with `lrc_chg` goes to SHIFT with `ch=lrc_i`, `cnt=0`.
- `enable_i=0` in any state goes to IDLE next cycle. The partial word and `left_ok` are discarded. FIFO contents stay readable.
- FIFO:
  - Show-ahead: outputs reflect the head whenever `level_o>0`. `sample_valid_o = (level_o!=0)`.
  - Pop on `valid & ready`.
  - A push when full with no pop drops the new frame and sets `overflow_o`.
  - A push and pop in the same cycle when full are both accepted; level is unchanged.
  - Read/write pointers wrap modulo FIFO_DEPTH.
- Sticky flags: `err_clr_i` clears both. If a set event and `err_clr_i` occur in the same cycle, set wins.

## Timing
- Reset (`rst_i` high at a `clk_i` edge):
  - State IDLE, FIFO empty, `level_o=0`.
  - `sample_valid_o=0`, `sample_left_o=0`, `sample_right_o=0`.
  - `overflow_o=0`, `framing_err_o=0`, `left_ok=0`, `lrc_prev=0`, `bclk_q=0`.
  - Applying reset mid-frame or with a non-empty FIFO flushes everything.
- `bclk_i` high and low phases must each be ≥2 `clk_i` cycles.
- Latency: let cycle N be the first cycle in which `bclk_i` is seen high for the last right-channel bit. The push is registered at the end of cycle N+1, and `sample_valid_o` / `level_o` update in cycle N+2.
- A pop takes effect at the end of the handshake cycle. The next head is presented in the following cycle.
- Throughput: one frame per LRC period. Consecutive pops are allowed every cycle.

## Test plan
- **Basic capture.** SAMPLE_W=16, 32 BCLK per slot, BCLK period 8 clk; drive L=0xA55A, R=0x1234 with `ready=1`.
  - Required: one pop of 0xA55A/0x1234.
  - Required: `valid` rises exactly 2 cycles after the last R bit's `rise` cycle.
- **Overflow.** Send 5 frames (L=n, R=0x100+n, n=1..5) with `ready=0`.
  - Required: `level_o=4` and `overflow_o=1`.
  - Required: draining yields n=1..4 in order; frame 5 is absent.
- **Mid-frame enable.** Assert `enable_i` during a right slot.
  - Required: that right word is not pushed; the first pushed frame is the next complete L/R pair.
- **Short slot.** LRC toggles after 10 bits of a left slot.
  - Required: `framing_err_o=1`, no push for that frame, and the following full frame is captured correctly.
- **Reset mid-frame.** Hold `rst_i` for 1 cycle with 2 frames queued and a partial left word in progress.
  - Required: `level_o=0`, `valid=0`, flags clear, and the next full frame is captured correctly.
- **Flag clear race and full-FIFO push/pop.**
  - `err_clr_i` in the same cycle as an overflow drop: `overflow_o` remains 1.
  - Push and pop in the same cycle with the FIFO full: level stays 4, no overflow.
